// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-port flash bridge arbiter.
package flash_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      RESP      = 2'd3
   } arb_state_t;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/flash_arb_rr.sv
// Two-way round-robin picker: on a tie the port not granted last wins.
module flash_arb_rr
   import flash_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic grant_valid,
   output logic grant_idx
);

   assign grant_valid = req0 | req1;

   always_comb begin
      grant_idx = PORT0;
      if (req0 && req1)
         grant_idx = ~last;
      else if (req1)
         grant_idx = PORT1;
   end

endmodule

// File: rtl/flash_arbiter.sv
// Arbitrates two requesters onto one flash bridge, one transaction at a time.
// Optional WAITING-phase abort is enabled by defining FLASH_ARB_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | no transaction; grant on any request
// ISSUE     | fb_start pulse, bridge latches address/direction/data
// WAIT_DONE | waiting for fb_done (or timeout when enabled)
// RESP      | ack (and err on timeout) to the granted port
module flash_arbiter
   import flash_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic       CLK_50MHZ,
   input  logic       RST_N,
   input  logic       req0,
   input  logic       req1,
   input  logic       rw0,
   input  logic       rw1,
   input  logic [7:0] addr0,
   input  logic [7:0] addr1,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   output logic       ack0,
   output logic       ack1,
   output logic       err0,
   output logic       err1,
   output logic [7:0] rdata,
   output logic       busy,
   output logic [7:0] fb_addr,
   output logic       fb_direction_rw,
   output logic [7:0] fb_wdata,
   output logic       fb_wdata_oe,
   input  logic [7:0] fb_rdata,
   output logic       fb_start,
   input  logic       fb_done
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("flash_arbiter: TIMEOUT_CYCLES must be 1..255");
   end

   arb_state_t state;
   logic       last;
   logic       idx;
   logic       grant_valid;
   logic       grant_idx;
   logic       sel_rw;
   logic [7:0] sel_addr;
   logic [7:0] sel_wdata;

   flash_arb_rr u_rr (
      .req0        (req0),
      .req1        (req1),
      .last        (last),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign sel_rw    = (grant_idx == PORT1) ? rw1    : rw0;
   assign sel_addr  = (grant_idx == PORT1) ? addr1  : addr0;
   assign sel_wdata = (grant_idx == PORT1) ? wdata1 : wdata0;

`ifdef FLASH_ARB_TIMEOUT_EN
   logic [7:0] wait_cnt;
`else
   assign err0 = 1'b0;
   assign err1 = 1'b0;
`endif

   always_ff @(posedge CLK_50MHZ) begin
      if (!RST_N) begin
         state           <= IDLE;
         last            <= PORT1;
         idx             <= PORT0;
         ack0            <= 1'b0;
         ack1            <= 1'b0;
         fb_start        <= 1'b0;
         fb_wdata_oe     <= 1'b0;
         busy            <= 1'b0;
         rdata           <= 8'h00;
         fb_addr         <= 8'h00;
         fb_wdata        <= 8'h00;
         fb_direction_rw <= 1'b1;
`ifdef FLASH_ARB_TIMEOUT_EN
         err0            <= 1'b0;
         err1            <= 1'b0;
         wait_cnt        <= 8'h00;
`endif
      end else begin
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         fb_start <= 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
         err0     <= 1'b0;
         err1     <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (grant_valid) begin
                  idx             <= grant_idx;
                  fb_direction_rw <= sel_rw;
                  fb_addr         <= sel_addr;
                  fb_wdata        <= sel_wdata;
                  fb_wdata_oe     <= ~sel_rw;
                  fb_start        <= 1'b1;
                  busy            <= 1'b1;
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
`ifdef FLASH_ARB_TIMEOUT_EN
               wait_cnt <= 8'h00;
`endif
               state    <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (fb_done) begin
                  if (fb_direction_rw)
                     rdata <= fb_rdata;
                  fb_wdata_oe <= 1'b0;
                  ack0        <= (idx == PORT0);
                  ack1        <= (idx == PORT1);
                  state       <= RESP;
`ifdef FLASH_ARB_TIMEOUT_EN
               end else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                  // abort: reads return zero so a stale value is never mistaken for data
                  if (fb_direction_rw)
                     rdata <= 8'h00;
                  fb_wdata_oe <= 1'b0;
                  ack0        <= (idx == PORT0);
                  ack1        <= (idx == PORT1);
                  err0        <= (idx == PORT0);
                  err1        <= (idx == PORT1);
                  state       <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
`endif
               end
            end
            RESP: begin
               last  <= idx;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/flash_arbiter.md
FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, WAITING-phase cycle limit (1..255) before abort; used only when FLASH_ARB_TIMEOUT_EN is defined.
REQ-002 SHALL have port: CLK_50MHZ  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: RST_N  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: req0, req1  in  1  requester N transaction request, level, held until its ack.
REQ-005 SHALL have ports: rw0, rw1  in  1  requester N direction, 1 = read, 0 = write; stable while reqN high.
REQ-006 SHALL have ports: addr0, addr1  in  8  requester N flash address; stable while reqN high.
REQ-007 SHALL have ports: wdata0, wdata1  in  8  requester N write data; stable while reqN high.
REQ-008 SHALL have ports: ack0, ack1  out  1  one-cycle completion pulse to requester N.
REQ-009 SHALL have ports: err0, err1  out  1  one-cycle timeout pulse, coincident with ackN.
REQ-010 SHALL have port: rdata  out  8  registered read data of the last completed read.
REQ-011 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-012 SHALL have ports: fb_addr  out  8, fb_direction_rw  out  1, fb_wdata  out  8  bridge address, direction and write data.
REQ-013 SHALL have port: fb_wdata_oe  out  1  high only while a write is in flight; top level drives the bridge data bus from fb_wdata when high.
REQ-014 SHALL have port: fb_rdata  in  8  bridge data bus as seen by the arbiter.
REQ-015 SHALL have ports: fb_start  out  1  bridge trigger, and fb_done  in  1  bridge one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE and RESP.
REQ-017 In IDLE, when req0 or req1 is high, SHALL latch the winner's index, rw, addr and wdata and move to ISSUE on the next edge.
REQ-018 SHALL arbitrate round-robin: if both req0 and req1 are high, the port not granted last wins; with a single request, that port wins.
REQ-019 SHALL assert fb_start for exactly one cycle, in ISSUE, then move to WAIT_DONE; fb_start is never high in any other state.
REQ-020 SHALL hold fb_addr, fb_direction_rw and fb_wdata constant from ISSUE through RESP, driven from latched values.
REQ-021 SHALL assert fb_wdata_oe in ISSUE and WAIT_DONE for writes only.
REQ-022 In WAIT_DONE, on fb_done = 1, SHALL capture fb_rdata into rdata if the transaction is a read, then move to RESP.
REQ-023 For writes, rdata SHALL remain unchanged.
REQ-024 In RESP, SHALL pulse ack of the granted port for one cycle, update last-grant and return to IDLE.
REQ-025 Minimum request-to-ack latency SHALL be 3 cycles plus the bridge's WAITING time.
REQ-026 A new grant SHALL NOT occur in the same cycle as RESP.
REQ-027 If reqN drops mid-transaction, the transaction SHALL still complete and ackN SHALL still pulse.
REQ-028 fb_done seen outside WAIT_DONE SHALL be ignored.
REQ-029 The unlatched requester SHALL be held off with no ack until granted.

Reset
REQ-030 While RST_N = 0 at a clock edge: state = IDLE, last-grant = port 1 (so port 0 wins the first tie), ack0/ack1/err0/err1/fb_start/fb_wdata_oe/busy = 0, rdata/fb_addr/fb_wdata = 8'h00, fb_direction_rw = 1.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no ack; the bridge is reset by the same system reset.

Configuration
REQ-032 With FLASH_ARB_TIMEOUT_EN defined, a counter SHALL clear on entering WAIT_DONE and increment each cycle there.
REQ-033 With FLASH_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES without fb_done, SHALL go to RESP, pulse ackN with errN, and load rdata = 8'h00 for reads.
REQ-034 Without FLASH_ARB_TIMEOUT_EN, WAIT_DONE SHALL wait indefinitely, err0/err1 SHALL be tied 0, and no counter SHALL be synthesized.

Structure
REQ-035 Package flash_arb_pkg SHALL hold the state encoding (2-bit, IDLE = 0, ISSUE = 1, WAIT_DONE = 2, RESP = 3), the port index constants and the default TIMEOUT_CYCLES.
REQ-036 Sub-module flash_arb_rr SHALL be the 2-way round-robin picker: inputs req0, req1, last; outputs grant_valid, grant_idx; combinational only.

Verification
REQ-037 Single read: req0 = 1, rw0 = 1, addr0 = 8'h12; bridge model returns 8'hA5 -> one fb_start pulse, fb_addr = 8'h12, ack0 pulse, rdata = 8'hA5, fb_wdata_oe never high.
REQ-038 Single write: req1 = 1, rw1 = 0, addr1 = 8'h40, wdata1 = 8'h3C -> fb_direction_rw = 0, fb_wdata = 8'h3C, fb_wdata_oe high ISSUE..WAIT_DONE, ack1 pulse, rdata unchanged.
REQ-039 Contention: req0 and req1 both high from reset, each held -> grant order 0, 1, 0, 1 over four transactions.
REQ-040 Reset mid-op: RST_N = 0 during WAIT_DONE -> next edge all outputs at reset values, no ack, then port 0 wins the next tie.
REQ-041 Timeout (macro on, TIMEOUT_CYCLES = 8): bridge never returns fb_done -> ack0 and err0 pulse together 8 cycles after entering WAIT_DONE, rdata = 8'h00.
REQ-042 Request drop: req0 deasserted one cycle after grant -> transaction completes and ack0 still pulses once.
